// File: rtl/icache_stage2_pkg.sv
// Shared icache geometry, miss FSM encoding and a one-hot priority helper.
package icache_stage2_pkg;

    localparam int ADDR_WIDTH     = 16;
    localparam int TAG_WIDTH      = 8;
    localparam int SET_BITS_WIDTH = 4;
    localparam int NUM_WAYS       = 4;
    localparam int TA_WORD_WIDTH  = NUM_WAYS * TAG_WIDTH;
    localparam int SA_WORD_WIDTH  = NUM_WAYS * 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    // Keeps only the lowest set bit, so way 0 wins ties.
    function automatic logic [NUM_WAYS-1:0] lowest_one(input logic [NUM_WAYS-1:0] v);
        return v & (~v + NUM_WAYS'(1));
    endfunction

endpackage

// File: rtl/icache_nru_sel.sv
// NRU helper: picks the refill victim and computes the status word after marking a way used.
// Latency: combinational. Backpressure: none.
// Marks set_way used+valid; once every valid way is used, only set_way keeps its used bit.
module icache_nru_sel
    import icache_stage2_pkg::*;
(
    input  logic [SA_WORD_WIDTH-1:0] sa_word,
    input  logic [NUM_WAYS-1:0]      set_way,
    output logic [NUM_WAYS-1:0]      victim,
    output logic [SA_WORD_WIDTH-1:0] next_sa
);

    logic [NUM_WAYS-1:0] used;
    logic [NUM_WAYS-1:0] valid;
    logic [NUM_WAYS-1:0] used_n;
    logic [NUM_WAYS-1:0] valid_n;

    always_comb begin
        used    = '0;
        valid   = '0;
        next_sa = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            used[w]  = sa_word[2*w+1];
            valid[w] = sa_word[2*w];
        end

        if (|(~valid))
            victim = lowest_one(~valid);
        else if (|(~used))
            victim = lowest_one(~used);
        else
            victim = NUM_WAYS'(1);

        used_n  = used | set_way;
        valid_n = valid | set_way;
        if ((used_n & valid_n) == valid_n)
            used_n = set_way;

        for (int w = 0; w < NUM_WAYS; w++) begin
            next_sa[2*w+1] = used_n[w];
            next_sa[2*w]   = valid_n[w];
        end
    end

endmodule

// File: rtl/icache_stage2.sv
// Icache stage 2: 4-way tag compare, NRU update and miss/refill FSM (optional stats: ICACHE_STAGE2_STATS_EN).
// Latency: hit/miss result and hit SA write one cycle after the lookup; refill writes in the UPDATE cycle.
// Backpressure: o_ready low outside IDLE or under i_halt; i_halt freezes all state and masks write/request valids.
module icache_stage2
    import icache_stage2_pkg::*;
#(
    parameter int METADATA_WIDTH = 16
)(
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      i_halt,
    input  logic [METADATA_WIDTH-1:0] i_metadata,
    input  logic                      i_metadata_valid,
    input  logic [TA_WORD_WIDTH-1:0]  i_ta_data,
    input  logic                      i_ta_data_valid,
    input  logic [SA_WORD_WIDTH-1:0]  i_sa_data,
    input  logic                      i_sa_data_valid,
    input  logic                      i_mem_ack,
    input  logic                      i_refill_done,
    output logic                      o_valid,
    output logic                      o_hit,
    output logic [NUM_WAYS-1:0]       o_hit_way,
    output logic [ADDR_WIDTH-1:0]     o_addr,
    output logic                      o_mem_req,
    output logic [ADDR_WIDTH-1:0]     o_mem_addr,
    output logic [ADDR_WIDTH-1:0]     o_w_ta_addr,
    output logic [TA_WORD_WIDTH-1:0]  o_w_ta_data,
    output logic [NUM_WAYS-1:0]       o_w_ta_mask,
    output logic                      o_w_ta_valid,
    output logic [ADDR_WIDTH-1:0]     o_w_sa_addr,
    output logic [SA_WORD_WIDTH-1:0]  o_w_sa_data,
    output logic [NUM_WAYS-1:0]       o_w_sa_mask,
    output logic                      o_w_sa_valid,
`ifdef ICACHE_STAGE2_STATS_EN
    output logic [15:0]               o_hit_count,
    output logic [15:0]               o_miss_count,
`endif
    output logic                      o_miss_state,
    output logic                      o_ready
);

    state_t state, state_nxt;

    logic                     lookup;
    logic                     idle_lookup;
    logic                     upd;
    logic [NUM_WAYS-1:0]      match;
    logic [NUM_WAYS-1:0]      hit_vec;
    logic                     hit;
    logic [SA_WORD_WIDTH-1:0] nru_sa;
    logic [NUM_WAYS-1:0]      nru_set;
    logic [NUM_WAYS-1:0]      nru_victim;
    logic [SA_WORD_WIDTH-1:0] nru_next;

    logic                     r_valid;
    logic                     r_hit;
    logic [NUM_WAYS-1:0]      r_way;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic                     r_sa_vld;
    logic [SA_WORD_WIDTH-1:0] r_sa_data;
    logic [ADDR_WIDTH-1:0]    miss_addr;
    logic [NUM_WAYS-1:0]      miss_victim;
    logic [SA_WORD_WIDTH-1:0] miss_sa;

    assign lookup      = i_metadata_valid & i_ta_data_valid & i_sa_data_valid;
    assign idle_lookup = lookup & ~i_halt & (state == ST_IDLE);
    assign upd         = (state == ST_UPDATE);

    always_comb begin
        match = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            match[w] = i_sa_data[2*w] && (i_ta_data[TAG_WIDTH*w +: TAG_WIDTH] == i_metadata[15:8]);
    end

    assign hit_vec = lowest_one(match);
    assign hit     = |match;

    // One NRU instance serves both the hit update (live SA word) and the refill update (latched SA word).
    assign nru_sa  = upd ? miss_sa : i_sa_data;
    assign nru_set = upd ? miss_victim : hit_vec;

    icache_nru_sel u_nru_sel (
        .sa_word (nru_sa),
        .set_way (nru_set),
        .victim  (nru_victim),
        .next_sa (nru_next)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (idle_lookup && !hit)          state_nxt = ST_REQ;
            ST_REQ:    if (!i_halt && i_mem_ack)         state_nxt = ST_WAIT;
            ST_WAIT:   if (!i_halt && i_refill_done)     state_nxt = ST_UPDATE;
            ST_UPDATE: if (!i_halt)                      state_nxt = ST_IDLE;
            default:                                     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_valid     <= 1'b0;
            r_hit       <= 1'b0;
            r_way       <= '0;
            r_addr      <= '0;
            r_sa_vld    <= 1'b0;
            r_sa_data   <= '0;
            miss_addr   <= '0;
            miss_victim <= '0;
            miss_sa     <= '0;
        end else if (!i_halt) begin
            r_valid  <= idle_lookup;
            r_hit    <= idle_lookup & hit;
            r_way    <= idle_lookup ? hit_vec : '0;
            r_sa_vld <= idle_lookup & hit;
            if (idle_lookup) begin
                r_addr    <= i_metadata;
                r_sa_data <= nru_next;
            end
            if (idle_lookup && !hit) begin
                miss_addr   <= i_metadata;
                miss_victim <= nru_victim;
                miss_sa     <= i_sa_data;
            end
        end
    end

    assign o_valid      = (r_valid | upd) & ~i_halt;
    assign o_hit        = r_hit | upd;
    assign o_hit_way    = upd ? miss_victim : r_way;
    assign o_addr       = upd ? miss_addr : r_addr;
    assign o_mem_req    = (state == ST_REQ) & ~i_halt;
    assign o_mem_addr   = {miss_addr[15:4], 4'h0};
    assign o_w_ta_addr  = upd ? miss_addr : '0;
    assign o_w_ta_data  = upd ? {NUM_WAYS{miss_addr[15:8]}} : '0;
    assign o_w_ta_mask  = upd ? miss_victim : '0;
    assign o_w_ta_valid = upd & ~i_halt;
    assign o_w_sa_addr  = upd ? miss_addr : r_addr;
    assign o_w_sa_data  = upd ? nru_next : r_sa_data;
    assign o_w_sa_mask  = (upd | r_sa_vld) ? 4'hF : 4'h0;
    assign o_w_sa_valid = (upd | r_sa_vld) & ~i_halt;
    assign o_miss_state = (state != ST_IDLE);
    assign o_ready      = ~i_halt & (state == ST_IDLE);

`ifdef ICACHE_STAGE2_STATS_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            o_hit_count  <= '0;
            o_miss_count <= '0;
        end else begin
            if (idle_lookup && hit && o_hit_count != 16'hFFFF)
                o_hit_count <= o_hit_count + 16'd1;
            if (idle_lookup && !hit && o_miss_count != 16'hFFFF)
                o_miss_count <= o_miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_stage2.sv
// Directed bench for icache_stage2: reset, hit/miss, NRU wrap, victim choice, halt and mid-miss reset.
module tb_icache_stage2;
    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] md = '0;
    logic        md_v = 1'b0;
    logic [31:0] ta = '0;
    logic        ta_v = 1'b0;
    logic [7:0]  sa = '0;
    logic        sa_v = 1'b0;
    logic        ack = 1'b0;
    logic        done = 1'b0;
    logic        o_valid, o_hit, o_mem_req, o_w_ta_valid, o_w_sa_valid, o_miss_state, o_ready;
    logic [3:0]  o_hit_way, o_w_ta_mask, o_w_sa_mask;
    logic [15:0] o_addr, o_mem_addr, o_w_ta_addr, o_w_sa_addr;
    logic [31:0] o_w_ta_data;
    logic [7:0]  o_w_sa_data;
`ifdef ICACHE_STAGE2_STATS_EN
    logic [15:0] o_hit_count, o_miss_count;
`endif
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    icache_stage2 dut (
        .clk(clk), .arst_n(arst_n), .i_halt(halt),
        .i_metadata(md), .i_metadata_valid(md_v),
        .i_ta_data(ta), .i_ta_data_valid(ta_v),
        .i_sa_data(sa), .i_sa_data_valid(sa_v),
        .i_mem_ack(ack), .i_refill_done(done),
        .o_valid(o_valid), .o_hit(o_hit), .o_hit_way(o_hit_way), .o_addr(o_addr),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .o_w_ta_addr(o_w_ta_addr), .o_w_ta_data(o_w_ta_data),
        .o_w_ta_mask(o_w_ta_mask), .o_w_ta_valid(o_w_ta_valid),
        .o_w_sa_addr(o_w_sa_addr), .o_w_sa_data(o_w_sa_data),
        .o_w_sa_mask(o_w_sa_mask), .o_w_sa_valid(o_w_sa_valid),
`ifdef ICACHE_STAGE2_STATS_EN
        .o_hit_count(o_hit_count), .o_miss_count(o_miss_count),
`endif
        .o_miss_state(o_miss_state), .o_ready(o_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one lookup for a single cycle; returns #1 after the sampling edge.
    task automatic drive_lookup(input logic [15:0] a, input logic [31:0] t, input logic [7:0] s);
        md = a; ta = t; sa = s;
        md_v = 1'b1; ta_v = 1'b1; sa_v = 1'b1;
        step();
        md_v = 1'b0; ta_v = 1'b0; sa_v = 1'b0;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        step();
        step();
        arst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if ({o_valid, o_hit, o_mem_req, o_w_ta_valid, o_w_sa_valid, o_miss_state} !== 6'b0) begin
            n_err++; $display("FAIL reset_outs got=%b want=000000", {o_valid, o_hit, o_mem_req, o_w_ta_valid, o_w_sa_valid, o_miss_state}); end
        n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b want=1", o_ready); end
`ifdef ICACHE_STAGE2_STATS_EN
        n_vec++; if ({o_hit_count, o_miss_count} !== 32'h0) begin
            n_err++; $display("FAIL reset_counts got=%h want=0", {o_hit_count, o_miss_count}); end
`endif
    endtask

    task automatic test_bubble();
        md = 16'hAB30; ta = 32'h000000AB; sa = 8'h01;
        md_v = 1'b1; ta_v = 1'b1; sa_v = 1'b0;
        step();
        md_v = 1'b0; ta_v = 1'b0;
        n_vec++; if ({o_valid, o_w_sa_valid, o_miss_state} !== 3'b000) begin
            n_err++; $display("FAIL bubble got=%b want=000", {o_valid, o_w_sa_valid, o_miss_state}); end
    endtask

    task automatic test_cold_miss();
        drive_lookup(16'hAB30, 32'h0, 8'h00);
        n_vec++; if ({o_valid, o_hit, o_mem_req, o_ready} !== 4'b1010) begin
            n_err++; $display("FAIL cold_miss_result got=%b want=1010", {o_valid, o_hit, o_mem_req, o_ready}); end
        n_vec++; if (o_mem_addr !== 16'hAB30) begin n_err++; $display("FAIL cold_mem_addr got=%h want=ab30", o_mem_addr); end
        ack = 1'b1; step(); ack = 1'b0;
        n_vec++; if ({o_mem_req, o_miss_state} !== 2'b01) begin
            n_err++; $display("FAIL cold_wait got=%b want=01", {o_mem_req, o_miss_state}); end
        done = 1'b1; step(); done = 1'b0;
        n_vec++; if ({o_w_ta_valid, o_w_ta_mask, o_w_ta_data} !== {1'b1, 4'b0001, 32'hABABABAB}) begin
            n_err++; $display("FAIL cold_ta_write got=%b/%b/%h want=1/0001/abababab", o_w_ta_valid, o_w_ta_mask, o_w_ta_data); end
        n_vec++; if ({o_w_sa_valid, o_w_sa_mask, o_w_sa_data} !== {1'b1, 4'hF, 8'h03}) begin
            n_err++; $display("FAIL cold_sa_write got=%b/%h/%h want=1/f/03", o_w_sa_valid, o_w_sa_mask, o_w_sa_data); end
        n_vec++; if ({o_valid, o_hit, o_hit_way, o_w_ta_addr} !== {2'b11, 4'b0001, 16'hAB30}) begin
            n_err++; $display("FAIL cold_update_result got=%b%b/%b/%h want=11/0001/ab30", o_valid, o_hit, o_hit_way, o_w_ta_addr); end
        step();
        n_vec++; if ({o_ready, o_miss_state, o_w_ta_valid, o_w_sa_valid, o_valid} !== 5'b10000) begin
            n_err++; $display("FAIL cold_back_idle got=%b want=10000", {o_ready, o_miss_state, o_w_ta_valid, o_w_sa_valid, o_valid}); end
    endtask

    task automatic test_hit();
        drive_lookup(16'hAB30, 32'h11AB2233, 8'h55);
        n_vec++; if ({o_valid, o_hit, o_hit_way, o_addr} !== {2'b11, 4'b0100, 16'hAB30}) begin
            n_err++; $display("FAIL hit_result got=%b%b/%b/%h want=11/0100/ab30", o_valid, o_hit, o_hit_way, o_addr); end
        n_vec++; if ({o_w_sa_valid, o_w_sa_data, o_w_sa_addr, o_w_ta_valid, o_mem_req} !== {1'b1, 8'h75, 16'hAB30, 2'b00}) begin
            n_err++; $display("FAIL hit_sa_write got=%b/%h/%h/%b%b want=1/75/ab30/00", o_w_sa_valid, o_w_sa_data, o_w_sa_addr, o_w_ta_valid, o_mem_req); end
        step();
        n_vec++; if ({o_valid, o_w_sa_valid, o_ready} !== 3'b001) begin
            n_err++; $display("FAIL hit_pulse got=%b want=001", {o_valid, o_w_sa_valid, o_ready}); end
    endtask

    task automatic test_nru_wrap();
        drive_lookup(16'hAB30, 32'h112233AB, 8'hFD);
        n_vec++; if ({o_hit, o_hit_way, o_w_sa_data} !== {1'b1, 4'b0001, 8'h57}) begin
            n_err++; $display("FAIL nru_wrap got=%b/%b/%h want=1/0001/57", o_hit, o_hit_way, o_w_sa_data); end
        step();
    endtask

    task automatic test_victim_all_valid();
        // Ack presented already in the lookup cycle: REQ must still last one cycle.
        ack = 1'b1;
        drive_lookup(16'hAB30, 32'h11223344, 8'hDF);
        n_vec++; if ({o_valid, o_hit, o_mem_req} !== 3'b101) begin
            n_err++; $display("FAIL victim_miss got=%b want=101", {o_valid, o_hit, o_mem_req}); end
        step(); ack = 1'b0;
        n_vec++; if ({o_mem_req, o_miss_state} !== 2'b01) begin
            n_err++; $display("FAIL victim_req_1cyc got=%b want=01", {o_mem_req, o_miss_state}); end
        done = 1'b1; step(); done = 1'b0;
        n_vec++; if ({o_w_ta_mask, o_w_sa_data, o_hit_way} !== {4'b0100, 8'h75, 4'b0100}) begin
            n_err++; $display("FAIL victim_update got=%b/%h/%b want=0100/75/0100", o_w_ta_mask, o_w_sa_data, o_hit_way); end
        step();
    endtask

    task automatic test_halt();
        drive_lookup(16'h5570, 32'h0, 8'h00);
        ack = 1'b1; step(); ack = 1'b0;
        done = 1'b1; step(); done = 1'b0;
        halt = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++; if ({o_w_ta_valid, o_w_sa_valid, o_mem_req, o_ready, o_miss_state} !== 5'b00001) begin
                n_err++; $display("FAIL halt_hold_%0d got=%b want=00001", c, {o_w_ta_valid, o_w_sa_valid, o_mem_req, o_ready, o_miss_state}); end
            if (c < 2) begin @(posedge clk); #1; end
        end
        halt = 1'b0;
        #1;
        n_vec++; if ({o_w_ta_valid, o_w_ta_mask, o_w_sa_valid, o_w_sa_data, o_ready} !== {1'b1, 4'b0001, 1'b1, 8'h03, 1'b0}) begin
            n_err++; $display("FAIL halt_release got=%b/%b/%b/%h/%b want=1/0001/1/03/0", o_w_ta_valid, o_w_ta_mask, o_w_sa_valid, o_w_sa_data, o_ready); end
        n_vec++; if (o_w_ta_addr !== 16'h5570) begin n_err++; $display("FAIL halt_ta_addr got=%h want=5570", o_w_ta_addr); end
        step();
        n_vec++; if ({o_ready, o_miss_state, o_w_ta_valid} !== 3'b100) begin
            n_err++; $display("FAIL halt_done got=%b want=100", {o_ready, o_miss_state, o_w_ta_valid}); end
    endtask

    task automatic test_reset_mid_wait();
        drive_lookup(16'h9910, 32'h0, 8'h00);
        ack = 1'b1; step(); ack = 1'b0;
        n_vec++; if (o_miss_state !== 1'b1) begin n_err++; $display("FAIL rst_pre_wait got=%b want=1", o_miss_state); end
        arst_n = 1'b0;
        #1;
        n_vec++; if ({o_valid, o_hit, o_hit_way, o_addr, o_mem_req, o_mem_addr, o_w_ta_valid, o_w_sa_valid, o_miss_state} !== 41'b0) begin
            n_err++; $display("FAIL rst_mid_outs got=%b%b/%b/%h/%b/%h/%b%b%b want=all zero", o_valid, o_hit, o_hit_way, o_addr, o_mem_req, o_mem_addr, o_w_ta_valid, o_w_sa_valid, o_miss_state); end
        n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready got=%b want=1", o_ready); end
`ifdef ICACHE_STAGE2_STATS_EN
        n_vec++; if ({o_hit_count, o_miss_count} !== 32'h0) begin
            n_err++; $display("FAIL rst_mid_counts got=%h want=0", {o_hit_count, o_miss_count}); end
`endif
        #1 arst_n = 1'b1;
        step();
        done = 1'b1; step(); done = 1'b0;
        n_vec++; if ({o_w_ta_valid, o_w_sa_valid, o_valid, o_miss_state} !== 4'b0000) begin
            n_err++; $display("FAIL rst_no_refill got=%b want=0000", {o_w_ta_valid, o_w_sa_valid, o_valid, o_miss_state}); end
        step();
        n_vec++; if ({o_w_ta_valid, o_w_sa_valid, o_ready} !== 3'b001) begin
            n_err++; $display("FAIL rst_idle_after got=%b want=001", {o_w_ta_valid, o_w_sa_valid, o_ready}); end
    endtask

    initial begin
        test_reset();
        test_bubble();
        test_cold_miss();
        test_hit();
        test_nru_wrap();
        test_victim_all_valid();
        test_halt();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
